// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA request arbiter with HRQ/HLDA bus-hold handshake and byte pacing.
// Optional rotating priority is enabled by defining DMA_ROTATE_PRIORITY_EN.
module dma_channel_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int BYTE_CYCLES  = 4,
    parameter int HLDA_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              mask_wr,
    input  logic [NUM_CH-1:0] mask_in,
    input  logic [NUM_CH-1:0] mode_in,
    input  logic              HLDA,
    input  logic              TC,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [1:0]        active_ch,
    output logic              xfer_stb,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_GRANT   = 3'd2;
    localparam logic [2:0] S_XFER    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam int          BW      = $clog2(BYTE_CYCLES);
    localparam logic [BW-1:0] BC_LAST = BW'(BYTE_CYCLES - 1);
    localparam logic [7:0]  TO_LAST = 8'(HLDA_TIMEOUT - 1);

    logic [2:0]        state;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] mode;
    logic [BW-1:0]     byte_cnt;
    logic [7:0]        to_cnt;
    logic [NUM_CH-1:0] eff;
    logic [1:0]        winner;
    logic              end_xfer;

    // Lowest-priority channel is visited first so the highest-priority hit wins last.
    function automatic logic [1:0] pick(input logic [NUM_CH-1:0] req, input logic [1:0] base);
        logic [1:0] idx;
        pick = base;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = base + 2'(i);
            if (req[idx]) pick = idx;
        end
    endfunction

    assign eff      = DREQ & ~mask;
    assign busy     = (state != S_IDLE);
    assign xfer_stb = (state == S_XFER) && HLDA && (byte_cnt == BC_LAST);
    assign end_xfer = TC | mask[active_ch] | ~mode[active_ch] | ~DREQ[active_ch];

`ifdef DMA_ROTATE_PRIORITY_EN
    logic [1:0] rot_ptr;

    // The channel that just completed drops to lowest priority.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            rot_ptr <= 2'd0;
        end else if (xfer_stb && end_xfer) begin
            rot_ptr <= active_ch + 2'd1;
        end
    end

    assign winner = pick(eff, rot_ptr);
`else
    assign winner = pick(eff, 2'd0);
`endif

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            mask <= '1;
            mode <= '0;
        end else if (mask_wr) begin
            mask <= mask_in;
            mode <= mode_in;
        end
    end

    // Handshake: HRQ is a level held from REQ until the transfer ends; HLDA is the
    // CPU's level reply. Losing HLDA in GRANT/XFER aborts at once, and RELEASE waits
    // for HLDA to fall before another HRQ can be raised.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            HRQ         <= 1'b0;
            DACK        <= '0;
            active_ch   <= 2'd0;
            byte_cnt    <= '0;
            to_cnt      <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (mask_wr) timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (eff != '0) begin
                        active_ch <= winner;
                        HRQ       <= 1'b1;
                        to_cnt    <= 8'd0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (HLDA) begin
                        to_cnt <= 8'd0;
                        state  <= S_GRANT;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt      <= 8'd0;
                        HRQ         <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                S_GRANT: begin
                    if (!HLDA) begin
                        HRQ   <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        DACK     <= NUM_CH'(1) << active_ch;
                        byte_cnt <= '0;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!HLDA) begin
                        DACK     <= '0;
                        HRQ      <= 1'b0;
                        byte_cnt <= '0;
                        state    <= S_IDLE;
                    end else if (byte_cnt == BC_LAST) begin
                        byte_cnt <= '0;
                        if (end_xfer) begin
                            DACK  <= '0;
                            HRQ   <= 1'b0;
                            state <= S_RELEASE;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + BW'(1);
                    end
                end
                S_RELEASE: begin
                    if (!HLDA) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: grants, timing, demand/TC, timeout,
// HLDA abort and asynchronous reset; xfer_stb events are matched against a queue.
module tb_dma_channel_arbiter;

    logic       clk;
    logic       RESET;
    logic [3:0] DREQ;
    logic       mask_wr;
    logic [3:0] mask_in;
    logic [3:0] mode_in;
    logic       HLDA;
    logic       TC;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] active_ch;
    logic       xfer_stb;
    logic       busy;
    logic       timeout_err;

    logic [5:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         cpu_auto = 0;

    dma_channel_arbiter #(.HLDA_TIMEOUT(8)) dut (
        .clk(clk), .RESET(RESET), .DREQ(DREQ), .mask_wr(mask_wr), .mask_in(mask_in),
        .mode_in(mode_in), .HLDA(HLDA), .TC(TC), .HRQ(HRQ), .DACK(DACK),
        .active_ch(active_ch), .xfer_stb(xfer_stb), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_mask(input logic [3:0] m, input logic [3:0] md);
        mask_in = m;
        mode_in = md;
        mask_wr = 1'b1;
        tick(1);
        mask_wr = 1'b0;
    endtask

    task automatic wait_dack(input logic [3:0] v, input int budget);
        int n = 0;
        while (DACK !== v && n < budget) begin
            tick(1);
            n++;
        end
        check("dack_wait", DACK, v);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // CPU model: acknowledges hold one clock after HRQ changes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cpu_auto) HLDA = HRQ;
        end
    end

    // Scoreboard: every byte strobe must match the next expected {active_ch, DACK}.
    initial begin
        forever begin
            @(negedge clk);
            if (!RESET && xfer_stb) begin
                if (exp_q.size() == 0) check("unexpected_stb", {active_ch, DACK}, 6'h3f);
                else check("stb_ch", {active_ch, DACK}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int stbs;
        RESET = 1'b1; DREQ = 4'b0; mask_wr = 1'b0; mask_in = 4'b0; mode_in = 4'b0;
        HLDA = 1'b0; TC = 1'b0;
        tick(2);
        RESET = 1'b0;
        tick(1);
        check("rst_hrq", HRQ, 0);
        check("rst_dack", DACK, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_ch", active_ch, 0);
        DREQ = 4'b1111;
        tick(3);
        check("rst_masked_hrq", HRQ, 0);
        DREQ = 4'b0;

        // Single byte on channel 2 with HLDA held high.
        load_mask(4'b0000, 4'b0000);
        HLDA = 1'b1;
        DREQ = 4'b0100;
        exp_q.push_back({2'd2, 4'b0100});
        tick(1);
        check("t1_hrq", HRQ, 1);
        check("t1_dack_early", DACK, 0);
        tick(1);
        check("t1_dack_grant", DACK, 0);
        tick(1);
        check("t1_dack", DACK, 4'b0100);
        DREQ = 4'b0;
        tick(2);
        check("t1_stb_early", xfer_stb, 0);
        tick(1);
        check("t1_stb", xfer_stb, 1);
        tick(1);
        check("t1_rel_hrq", HRQ, 0);
        check("t1_rel_dack", DACK, 0);
        check("t1_rel_busy", busy, 1);
        HLDA = 1'b0;
        tick(1);
        check("t1_idle", busy, 0);

        // Channels 1 and 3 together: 1 first, 3 only after a fresh HRQ.
        cpu_auto = 1;
        DREQ = 4'b1010;
        exp_q.push_back({2'd1, 4'b0010});
        exp_q.push_back({2'd3, 4'b1000});
        wait_dack(4'b0010, 10);
        check("t2_first_ch", active_ch, 1);
        DREQ = 4'b1000;
        tick(4);
        check("t2_rel_hrq", HRQ, 0);
        check("t2_rel_dack", DACK, 0);
        tick(1);
        check("t2_idle_hrq", HRQ, 0);
        tick(1);
        check("t2_rehrq", HRQ, 1);
        check("t2_second_ch", active_ch, 3);
        tick(2);
        check("t2_dack3", DACK, 4'b1000);
        DREQ = 4'b0;
        wait_drain(20);
        tick(3);

        // All channels held: grant order depends on the priority scheme.
`ifdef DMA_ROTATE_PRIORITY_EN
        exp_q.push_back({2'd0, 4'b0001});
        exp_q.push_back({2'd1, 4'b0010});
        exp_q.push_back({2'd2, 4'b0100});
        exp_q.push_back({2'd3, 4'b1000});
        exp_q.push_back({2'd0, 4'b0001});
`else
        for (int i = 0; i < 5; i++) exp_q.push_back({2'd0, 4'b0001});
`endif
        DREQ = 4'b1111;
        wait_drain(200);
        DREQ = 4'b0;
        tick(3);
        check("t_order_idle", busy, 0);

        // Demand mode on channel 2, TC on the third byte.
        load_mask(4'b0000, 4'b0100);
        for (int i = 0; i < 3; i++) exp_q.push_back({2'd2, 4'b0100});
        DREQ = 4'b0100;
        stbs = 0;
        for (int n = 0; n < 100; n++) begin
            tick(1);
            if (xfer_stb) begin
                stbs++;
                if (stbs == 3) begin
                    TC = 1'b1;
                    tick(1);
                    TC = 1'b0;
                    break;
                end
            end
        end
        check("t3_stbs", stbs, 3);
        check("t3_rel_hrq", HRQ, 0);
        check("t3_rel_dack", DACK, 0);
        DREQ = 4'b0;
        tick(4);
        check("t3_idle", busy, 0);
        check("t3_drain", exp_q.size(), 0);

        // No HLDA: request abandoned after 8 clocks in REQ.
        cpu_auto = 0;
        HLDA = 1'b0;
        DREQ = 4'b0001;
        tick(1);
        check("t4_hrq", HRQ, 1);
        DREQ = 4'b0;
        tick(7);
        check("t4_hrq_held", HRQ, 1);
        check("t4_terr_early", timeout_err, 0);
        tick(1);
        check("t4_hrq_drop", HRQ, 0);
        check("t4_terr", timeout_err, 1);
        check("t4_busy", busy, 0);
        tick(3);
        check("t4_terr_sticky", timeout_err, 1);
        load_mask(4'b0000, 4'b0000);
        check("t4_terr_clr", timeout_err, 0);

        // HLDA withdrawn during the last clock of a byte: no strobe.
        cpu_auto = 1;
        DREQ = 4'b0001;
        wait_dack(4'b0001, 10);
        tick(3);
        check("t5_stb_before", xfer_stb, 1);
        cpu_auto = 0;
        HLDA = 1'b0;
        DREQ = 4'b0;
        #1;
        check("t5_stb_gated", xfer_stb, 0);
        tick(1);
        check("t5_dack", DACK, 0);
        check("t5_hrq", HRQ, 0);
        check("t5_busy", busy, 0);

        // Asynchronous reset mid-byte.
        cpu_auto = 1;
        DREQ = 4'b0001;
        wait_dack(4'b0001, 10);
        tick(2);
        RESET = 1'b1;
        #1;
        check("t6_hrq", HRQ, 0);
        check("t6_dack", DACK, 0);
        check("t6_busy", busy, 0);
        check("t6_stb", xfer_stb, 0);
        #2;
        RESET = 1'b0;
        tick(4);
        check("t6_masked_hrq", HRQ, 0);
        DREQ = 4'b0;
        tick(2);

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
